// File: rtl/fir_decimator_pkg.sv
// rtl/fir_decimator_pkg.sv - shared types and helpers for the FIR decimator
package fir_decimator_pkg;

  typedef enum logic [1:0] {
    WAIT_TICK = 2'd0,
    DELAY     = 2'd1,
    CAPTURE   = 2'd2
  } state_t;

  localparam int DEFAULT_BITS = 16;

  typedef logic signed [DEFAULT_BITS-1:0] sample_t;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int min_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_decimator_fifo.sv
// rtl/fir_decimator_fifo.sv - first-word fall-through FIFO with registered head
module sync_fifo_fwft #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             drop_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] data_q, head_val;
  logic             empty, full, do_pop, do_push;

  assign cnt     = wr_q - rd_q;
  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push_i & (~full | do_pop);
  assign drop_o  = push_i & full & ~do_pop;

  assign valid_o = ~empty;
  assign count_o = CW'(cnt);
  assign data_o  = data_q;

  // Pointer next-state; clear returns both pointers to zero
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (clear_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  // Next head: forward the incoming word when it lands in the head slot
  always_comb begin
    head_val = mem_q[rd_d[AW-1:0]];
    if (do_push && (wr_q[AW-1:0] == rd_d[AW-1:0])) head_val = data_i;
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  // Pointers and registered head; head holds its last value when empty
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q   <= '0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (!clear_i && (wr_d != rd_d)) data_q <= head_val;
    end
  end

endmodule

// File: rtl/fir_decimator.sv
// rtl/fir_decimator.sv - delayed capture, decimation and buffering of FIR output
module fir_decimator
  import fir_decimator_pkg::*;
#(
  parameter  int num_of_bits_io = 16,
  parameter  int CAPTURE_DELAY  = 5,
  parameter  int DECIMATION     = 4,
  parameter  int FIFO_DEPTH     = 8,
  localparam int CW             = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      tick_i,
  input  logic [num_of_bits_io-1:0] signal_i,
  input  logic                      clear_i,
  output logic [num_of_bits_io-1:0] data_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [CW-1:0]             count_o,
  output logic                      overflow_o
);

  localparam int DW   = min_width(CAPTURE_DELAY);
  localparam int PH_W = min_width(DECIMATION);

  state_t          state_q;
  logic [DW-1:0]   delay_q;
  logic [PH_W-1:0] phase_q;
  logic            overflow_q;
  logic            push_req, pop_req, fifo_drop;

  assign push_req   = (state_q == CAPTURE) && (phase_q == '0) && !clear_i;
  assign pop_req    = valid_o & ready_i;
  assign overflow_o = overflow_q;

  // Tick-to-capture sequencer; the counter reaches zero as CAPTURE is entered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= WAIT_TICK;
      delay_q <= '0;
    end else begin
      case (state_q)
        WAIT_TICK: begin
          if (tick_i) begin
            delay_q <= DW'(CAPTURE_DELAY - 1);
            if (CAPTURE_DELAY == 1) state_q <= CAPTURE;
            else                    state_q <= DELAY;
          end
        end
        DELAY: begin
          delay_q <= delay_q - 1'b1;
          if (delay_q == DW'(1)) state_q <= CAPTURE;
        end
        CAPTURE: state_q <= WAIT_TICK;
        default: state_q <= WAIT_TICK;
      endcase
    end
  end

  // Decimation phase and sticky overflow; clear wins over both
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear_i) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (state_q == CAPTURE) begin
        if (phase_q == PH_W'(DECIMATION - 1)) phase_q <= '0;
        else                                  phase_q <= phase_q + 1'b1;
      end
      if (fifo_drop) overflow_q <= 1'b1;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (num_of_bits_io),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_req),
    .data_i  (signal_i),
    .pop_i   (pop_req),
    .clear_i (clear_i),
    .data_o  (data_o),
    .valid_o (valid_o),
    .drop_o  (fifo_drop),
    .count_o (count_o)
  );

endmodule

// File: tb/tb_fir_decimator.sv
// tb/tb_fir_decimator.sv - self-checking bench for fir_decimator
module tb_fir_decimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic [15:0] sig = '0;
  logic        clear = 1'b0;
  logic        ready = 1'b0;

  logic [15:0] data0, data1;
  logic        valid0, valid1, ovf0, ovf1;
  logic [3:0]  count0, count1;

  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  fir_decimator dut (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .signal_i(sig), .clear_i(clear),
    .data_o(data0), .valid_o(valid0), .ready_i(ready), .count_o(count0), .overflow_o(ovf0)
  );

  fir_decimator #(.DECIMATION(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .signal_i(sig), .clear_i(clear),
    .data_o(data1), .valid_o(valid1), .ready_i(ready), .count_o(count1), .overflow_o(ovf1)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: tick acceptance window plus a queue per instance
  logic [15:0] mq [2][$];
  int          m_cyc, m_cap;
  bit          m_busy;
  int          m_phase [2];
  bit          m_ovf [2];
  logic [15:0] m_data [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mq[k].delete();
        m_phase[k] = 0;
        m_ovf[k] = 0;
        m_data[k] = '0;
      end
      m_cyc = 0;
      m_cap = 0;
      m_busy = 0;
    end else begin
      bit cap_now;
      int n;
      bit pop;
      m_cyc++;
      cap_now = m_busy && (m_cyc == m_cap);
      for (int k = 0; k < 2; k++) begin
        n = mq[k].size();
        pop = (n > 0) && ready;
        if (clear) begin
          mq[k].delete();
          m_phase[k] = 0;
          m_ovf[k] = 0;
        end else begin
          if (pop) void'(mq[k].pop_front());
          if (cap_now) begin
            if (m_phase[k] == 0) begin
              if (n < 8 || pop) mq[k].push_back(sig);
              else m_ovf[k] = 1;
            end
            m_phase[k] = (m_phase[k] + 1) % (k == 0 ? 4 : 1);
          end
          if (mq[k].size() > 0) m_data[k] = mq[k][0];
        end
      end
      if (cap_now) m_busy = 0;
      else if (!m_busy && tick) begin
        m_busy = 1;
        m_cap = m_cyc + 5;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("m0_valid", int'(valid0), int'(mq[0].size() > 0));
      chk("m0_count", int'(count0), mq[0].size());
      chk("m0_data",  int'(data0),  int'(m_data[0]));
      chk("m0_ovf",   int'(ovf0),   int'(m_ovf[0]));
      chk("m1_valid", int'(valid1), int'(mq[1].size() > 0));
      chk("m1_count", int'(count1), mq[1].size());
      chk("m1_data",  int'(data1),  int'(m_data[1]));
      chk("m1_ovf",   int'(ovf1),   int'(m_ovf[1]));
    end
  end

  // Words handed over to the consumer, sampled mid-cycle
  logic [15:0] got0[$], got1[$];
  always @(negedge clk) begin
    #2;
    if (rst_n && ready) begin
      if (valid0) got0.push_back(data0);
      if (valid1) got1.push_back(data1);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; tick = 0; clear = 0; ready = 0; sig = '0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    got0.delete();
    got1.delete();
  endtask

  task automatic do_tick(input logic [15:0] v, input int gap);
    @(negedge clk);
    tick = 1; sig = v;
    @(negedge clk);
    tick = 0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic drain(input int cycles);
    @(negedge clk);
    ready = 1;
    repeat (cycles) @(negedge clk);
    ready = 0;
  endtask

  typedef struct {
    logic [15:0] sig;
    int          exp_count;
    bit          exp_ovf;
  } vec_t;

  vec_t vec [9];
  int   ready_pct;

  initial begin
    for (int i = 0; i < 9; i++) begin
      vec[i].sig = 16'(i + 1);
      vec[i].exp_count = (i + 1 > 8) ? 8 : i + 1;
      vec[i].exp_ovf = (i == 8);
    end

    do_reset();
    chk("reset_valid", int'(valid0), 0);
    chk("reset_count", int'(count0), 0);
    chk("reset_data",  int'(data0),  0);
    chk("reset_ovf",   int'(ovf0),   0);
    chk_en = 1;

    // latency: tick at E0, word visible after E5, consumed at E6
    ready = 1;
    @(negedge clk);
    tick = 1; sig = 16'h1234;
    @(negedge clk);
    tick = 0;
    repeat (4) @(negedge clk);
    chk("lat_valid_e4", int'(valid0), 0);
    @(negedge clk);
    chk("lat_valid_e5", int'(valid0), 1);
    chk("lat_data_e5",  int'(data0),  16'h1234);
    @(negedge clk);
    chk("lat_valid_e6", int'(valid0), 0);
    chk("lat_data_hold", int'(data0), 16'h1234);

    // decimation by 4 keeps the 1st and 5th of eight captures
    do_reset();
    ready = 1;
    for (int i = 1; i <= 8; i++) do_tick(16'(i), 10);
    repeat (5) @(negedge clk);
    chk("dec_n_out", got0.size(), 2);
    if (got0.size() == 2) begin
      chk("dec_out0", int'(got0[0]), 1);
      chk("dec_out1", int'(got0[1]), 5);
    end
    chk("dec1_n_out", got1.size(), 8);

    // overflow with DECIMATION=1 and a stalled consumer, table-driven
    do_reset();
    for (int i = 0; i < 9; i++) begin
      do_tick(vec[i].sig, 10);
      chk($sformatf("ovf_count_%0d", i), int'(count1), vec[i].exp_count);
      chk($sformatf("ovf_flag_%0d", i),  int'(ovf1),   int'(vec[i].exp_ovf));
    end
    drain(12);
    chk("ovf_drain_n", got1.size(), 8);
    for (int i = 0; i < got1.size() && i < 8; i++)
      chk($sformatf("ovf_drain_%0d", i), int'(got1[i]), i + 1);

    // full FIFO with a pop on the capture edge accepts the push
    do_reset();
    for (int i = 1; i <= 8; i++) do_tick(16'(i), 10);
    chk("full_count", int'(count1), 8);
    @(negedge clk);
    tick = 1; sig = 16'd9;
    @(negedge clk);
    tick = 0;
    repeat (4) @(negedge clk);
    ready = 1;
    @(negedge clk);
    ready = 0;
    chk("fullpop_count", int'(count1), 8);
    chk("fullpop_ovf",   int'(ovf1),   0);
    chk("fullpop_head",  int'(data1),  2);
    drain(12);
    chk("fullpop_n", got1.size(), 9);
    for (int i = 0; i < got1.size() && i < 9; i++)
      chk($sformatf("fullpop_drain_%0d", i), int'(got1[i]), i + 1);

    // tick during DELAY is ignored; clear empties the FIFO
    do_reset();
    @(negedge clk);
    tick = 1; sig = 16'd7;
    @(negedge clk);
    tick = 0;
    @(negedge clk);
    tick = 1;
    @(negedge clk);
    tick = 0;
    repeat (15) @(negedge clk);
    chk("ign_count", int'(count1), 1);
    do_tick(16'd8, 10);
    do_tick(16'd9, 10);
    chk("clr_pre_count", int'(count1), 3);
    @(negedge clk);
    clear = 1;
    @(negedge clk);
    clear = 0;
    chk("clr_count1", int'(count1), 0);
    chk("clr_valid1", int'(valid1), 0);
    chk("clr_ovf1",   int'(ovf1),   0);
    chk("clr_count0", int'(count0), 0);

    // randomized traffic with an asynchronous reset in the middle
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (c % 200 == 0) ready_pct = (c / 200) % 3 == 0 ? 10 : ((c / 200) % 3 == 1 ? 60 : 95);
      tick  = ($urandom % 4) == 0;
      sig   = 16'($urandom);
      ready = ($urandom % 100) < ready_pct;
      clear = ($urandom % 97) == 0;
      if (c == 777) begin
        #3;
        rst_n = 0;
        #1;
        chk("async_valid", int'(valid0), 0);
        chk("async_count", int'(count0), 0);
        chk("async_data",  int'(data0),  0);
        chk("async_ovf",   int'(ovf0),   0);
        chk("async_ovf1",  int'(ovf1),   0);
        @(negedge clk);
        rst_n = 1;
      end
    end
    @(negedge clk);
    tick = 0; clear = 0; ready = 0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
